// File: rtl/dsp_mac_feeder_if.sv
// rtl/dsp_mac_feeder_if.sv - operand-pair input stream and dot-product result stream
interface dsp_mac_feeder_if #(
    parameter int A_WIDTH   = 25,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_WIDTH-1:0]   in_a;
    logic signed [B_WIDTH-1:0]   in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic                        out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/dsp_mac_feeder.sv
// rtl/dsp_mac_feeder.sv - operand sequencer and dot-product accumulator around a DSP48E1 multiplier
module dsp_mac_feeder #(
    parameter int A_WIDTH   = 25,
    parameter int B_WIDTH   = 18,
    parameter int MULT_LAT  = 3,
    parameter int VEC_LEN   = 16,
    parameter int ACC_WIDTH = 48
) (
    input  logic               CLK,
    input  logic               RST,
    dsp_mac_feeder_if.slave    s,
    output logic signed [29:0] dsp_a,
    output logic signed [17:0] dsp_b,
    output logic               dsp_ce,
    output logic               dsp_rst,
    input  logic signed [47:0] dsp_p
);
    localparam int             CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    logic [MULT_LAT-1:0]         r_vpipe;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out_sum;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_ovf;
    logic                        r_out_valid;
    logic                        r_out_ovf;

    logic                        w_stall;
    logic                        w_accept;
    logic                        w_pv;
    logic                        w_last;
    logic                        w_add_ovf;
    logic signed [ACC_WIDTH-1:0] w_p_ext;
    logic signed [ACC_WIDTH-1:0] w_next;

    // A full, unconsumed result freezes the slice and the tag pipe together
    assign w_stall    = r_out_valid & ~s.out_ready;
    assign dsp_ce     = ~w_stall;
    assign dsp_rst    = RST;
    assign s.in_ready = ~w_stall & ~RST;
    assign w_accept   = s.in_valid & s.in_ready;

    assign dsp_a = 30'($signed(s.in_a));
    assign dsp_b = 18'($signed(s.in_b));

    assign w_pv      = r_vpipe[MULT_LAT-1] & dsp_ce;
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_p_ext   = ACC_WIDTH'($signed(dsp_p));
    assign w_next    = r_acc + w_p_ext;
    assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_p_ext[ACC_WIDTH-1]) &&
                       (w_next[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

    assign s.out_valid = r_out_valid;
    assign s.out_sum   = r_out_sum;
    assign s.out_ovf   = r_out_ovf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vpipe <= '0;
        end else if (dsp_ce) begin
            r_vpipe[0] <= w_accept;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_pv && w_last) begin
                r_out_sum   <= w_next;
                r_out_ovf   <= r_ovf | w_add_ovf;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_ovf       <= 1'b0;
                r_cnt       <= '0;
            end else begin
                if (w_pv) begin
                    r_acc <= w_next;
                    r_ovf <= r_ovf | w_add_ovf;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_out_valid && s.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end
endmodule
